// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX-to-MEM stage bus with forwarding return paths
interface mem_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // EX stage outputs feeding the EX/MEM latch
    logic [DATA_WIDTH-1:0] i_ex_alu_result;
    logic [DATA_WIDTH-1:0] i_ex_write_data;
    logic [4:0]            i_ex_rd;
    logic                  i_ex_mem_read;
    logic                  i_ex_mem_write;
    logic                  i_ex_mem_to_reg;
    logic                  i_ex_reg_write;

    // Forwarding values returned to the EX muxes
    logic [DATA_WIDTH-1:0] o_ex_m_alu_result;
    logic [4:0]            o_ex_m_rd;
    logic                  o_ex_m_reg_write;
    logic [DATA_WIDTH-1:0] o_m_wb_data_write;
    logic [4:0]            o_m_wb_rd;
    logic                  o_m_wb_reg_write;

    // EX side: drives the instruction fields, consumes the forwarding values
    modport master (
        output i_ex_alu_result,
        output i_ex_write_data,
        output i_ex_rd,
        output i_ex_mem_read,
        output i_ex_mem_write,
        output i_ex_mem_to_reg,
        output i_ex_reg_write,
        input  o_ex_m_alu_result,
        input  o_ex_m_rd,
        input  o_ex_m_reg_write,
        input  o_m_wb_data_write,
        input  o_m_wb_rd,
        input  o_m_wb_reg_write
    );

    // MEM stage side
    modport slave (
        input  i_ex_alu_result,
        input  i_ex_write_data,
        input  i_ex_rd,
        input  i_ex_mem_read,
        input  i_ex_mem_write,
        input  i_ex_mem_to_reg,
        input  i_ex_reg_write,
        output o_ex_m_alu_result,
        output o_ex_m_rd,
        output o_ex_m_reg_write,
        output o_m_wb_data_write,
        output o_m_wb_rd,
        output o_m_wb_reg_write
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX/MEM latch, data memory, MEM/WB latch, debug port
module mem_stage #(
    parameter int MEM_ADDR_BITS = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_halt,
    mem_stage_if.slave               bus,
    input  logic [MEM_ADDR_BITS-1:0] i_dbg_addr,
    output logic [DATA_WIDTH-1:0]    o_dbg_data,
    output logic                     o_misaligned
);
    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    // EX/MEM latch
    logic [DATA_WIDTH-1:0] ex_m_alu_result_q, ex_m_alu_result_d;
    logic [DATA_WIDTH-1:0] ex_m_write_data_q, ex_m_write_data_d;
    logic [4:0]            ex_m_rd_q,         ex_m_rd_d;
    logic                  ex_m_mem_read_q,   ex_m_mem_read_d;
    logic                  ex_m_mem_write_q,  ex_m_mem_write_d;
    logic                  ex_m_mem_to_reg_q, ex_m_mem_to_reg_d;
    logic                  ex_m_reg_write_q,  ex_m_reg_write_d;

    // MEM/WB latch
    logic [DATA_WIDTH-1:0] m_wb_data_q,      m_wb_data_d;
    logic [4:0]            m_wb_rd_q,        m_wb_rd_d;
    logic                  m_wb_reg_write_q, m_wb_reg_write_d;

    // Sticky flag and debug read register
    logic                  misaligned_q, misaligned_d;
    logic [DATA_WIDTH-1:0] dbg_data_q;

    // Data memory; never reset so contents survive a pipeline reset
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic                     access_misaligned;
    logic                     mem_we;
    logic [DATA_WIDTH-1:0]    read_data;

    // Word index drops the byte offset; upper address bits wrap modulo depth
    assign mem_addr = ex_m_alu_result_q[MEM_ADDR_BITS+1:2];

    // Address decode, write enable and load data for the entry held in EX/MEM
    always_comb begin
        access_misaligned = (ex_m_mem_read_q || ex_m_mem_write_q) &&
                            (ex_m_alu_result_q[1:0] != 2'b00);
        mem_we            = !i_halt && ex_m_mem_write_q && !access_misaligned;
        // Old word is returned even if a store to the same word lands this edge
        read_data         = access_misaligned ? '0 : mem_q[mem_addr];
    end

    // Next-state for both latches and the sticky flag; halt holds everything
    always_comb begin
        ex_m_alu_result_d = ex_m_alu_result_q;
        ex_m_write_data_d = ex_m_write_data_q;
        ex_m_rd_d         = ex_m_rd_q;
        ex_m_mem_read_d   = ex_m_mem_read_q;
        ex_m_mem_write_d  = ex_m_mem_write_q;
        ex_m_mem_to_reg_d = ex_m_mem_to_reg_q;
        ex_m_reg_write_d  = ex_m_reg_write_q;
        m_wb_data_d       = m_wb_data_q;
        m_wb_rd_d         = m_wb_rd_q;
        m_wb_reg_write_d  = m_wb_reg_write_q;
        misaligned_d      = misaligned_q;
        if (!i_halt) begin
            ex_m_alu_result_d = bus.i_ex_alu_result;
            ex_m_write_data_d = bus.i_ex_write_data;
            ex_m_rd_d         = bus.i_ex_rd;
            ex_m_mem_read_d   = bus.i_ex_mem_read;
            ex_m_mem_write_d  = bus.i_ex_mem_write;
            ex_m_mem_to_reg_d = bus.i_ex_mem_to_reg;
            // $zero is never a forwarding or write-back target
            ex_m_reg_write_d  = bus.i_ex_reg_write && (bus.i_ex_rd != 5'd0);
            m_wb_data_d       = ex_m_mem_to_reg_q ? read_data : ex_m_alu_result_q;
            m_wb_rd_d         = ex_m_rd_q;
            m_wb_reg_write_d  = ex_m_reg_write_q;
            misaligned_d      = misaligned_q || access_misaligned;
        end
    end

    // Pipeline latch, sticky flag and debug register state
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ex_m_alu_result_q <= '0;
            ex_m_write_data_q <= '0;
            ex_m_rd_q         <= '0;
            ex_m_mem_read_q   <= 1'b0;
            ex_m_mem_write_q  <= 1'b0;
            ex_m_mem_to_reg_q <= 1'b0;
            ex_m_reg_write_q  <= 1'b0;
            m_wb_data_q       <= '0;
            m_wb_rd_q         <= '0;
            m_wb_reg_write_q  <= 1'b0;
            misaligned_q      <= 1'b0;
            dbg_data_q        <= '0;
        end else begin
            ex_m_alu_result_q <= ex_m_alu_result_d;
            ex_m_write_data_q <= ex_m_write_data_d;
            ex_m_rd_q         <= ex_m_rd_d;
            ex_m_mem_read_q   <= ex_m_mem_read_d;
            ex_m_mem_write_q  <= ex_m_mem_write_d;
            ex_m_mem_to_reg_q <= ex_m_mem_to_reg_d;
            ex_m_reg_write_q  <= ex_m_reg_write_d;
            m_wb_data_q       <= m_wb_data_d;
            m_wb_rd_q         <= m_wb_rd_d;
            m_wb_reg_write_q  <= m_wb_reg_write_d;
            misaligned_q      <= misaligned_d;
            // Debug port keeps reading through halt; sees pre-store contents
            dbg_data_q        <= mem_q[i_dbg_addr];
        end
    end

    // Memory write port: aligned stores commit only when not halted
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= ex_m_write_data_q;
        end
    end

    assign bus.o_ex_m_alu_result = ex_m_alu_result_q;
    assign bus.o_ex_m_rd         = ex_m_rd_q;
    assign bus.o_ex_m_reg_write  = ex_m_reg_write_q;
    assign bus.o_m_wb_data_write = m_wb_data_q;
    assign bus.o_m_wb_rd         = m_wb_rd_q;
    assign bus.o_m_wb_reg_write  = m_wb_reg_write_q;
    assign o_dbg_data            = dbg_data_q;
    assign o_misaligned          = misaligned_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a transaction-level model
module tb_mem_stage;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          halt     = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [31:0]   dbg_data;
    logic          misaligned;

    mem_stage_if #(.DATA_WIDTH(32)) bus ();

    mem_stage #(.MEM_ADDR_BITS(AW), .DATA_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_halt       (halt),
        .bus          (bus),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data   (dbg_data),
        .o_misaligned (misaligned)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
    } entry_t;

    entry_t      m_exm;
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH] = '{default: 1'b0};
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_rd;
    logic        m_wb_rw;
    bit          m_wb_known;
    logic [31:0] m_dbg;
    bit          m_dbg_known;
    logic        m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_exm       = '0;
            m_wb_data   = 32'd0;
            m_wb_rd     = 5'd0;
            m_wb_rw     = 1'b0;
            m_wb_known  = 1'b1;
            m_dbg       = 32'd0;
            m_dbg_known = 1'b1;
            m_mis       = 1'b0;
        end else begin
            int          idx;
            bit          mis;
            logic [31:0] rdata;
            bit          rknown;
            m_dbg       = m_mem[dbg_addr];
            m_dbg_known = m_known[dbg_addr];
            if (!halt) begin
                idx    = int'((m_exm.alu / 4) % DEPTH);
                mis    = (m_exm.alu % 4 != 0) && (m_exm.mr || m_exm.mw);
                rdata  = mis ? 32'd0 : m_mem[idx];
                rknown = mis ? 1'b1 : m_known[idx];
                m_wb_data  = m_exm.m2r ? rdata : m_exm.alu;
                m_wb_known = m_exm.m2r ? rknown : 1'b1;
                m_wb_rd    = m_exm.rd;
                m_wb_rw    = m_exm.rw;
                if (m_exm.mw && !mis) begin
                    m_mem[idx]   = m_exm.wd;
                    m_known[idx] = 1'b1;
                end
                if (mis) m_mis = 1'b1;
                m_exm.alu = bus.i_ex_alu_result;
                m_exm.wd  = bus.i_ex_write_data;
                m_exm.rd  = bus.i_ex_rd;
                m_exm.mr  = bus.i_ex_mem_read;
                m_exm.mw  = bus.i_ex_mem_write;
                m_exm.m2r = bus.i_ex_mem_to_reg;
                m_exm.rw  = bus.i_ex_reg_write && (bus.i_ex_rd != 5'd0);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit check_en = 1'b0;

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check("ex_m_alu_result", bus.o_ex_m_alu_result, m_exm.alu);
            check("ex_m_rd", 32'(bus.o_ex_m_rd), 32'(m_exm.rd));
            check("ex_m_reg_write", 32'(bus.o_ex_m_reg_write), 32'(m_exm.rw));
            if (m_wb_known) check("m_wb_data_write", bus.o_m_wb_data_write, m_wb_data);
            check("m_wb_rd", 32'(bus.o_m_wb_rd), 32'(m_wb_rd));
            check("m_wb_reg_write", 32'(bus.o_m_wb_reg_write), 32'(m_wb_rw));
            check("misaligned", 32'(misaligned), 32'(m_mis));
            if (m_dbg_known) check("dbg_data", dbg_data, m_dbg);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic m2r, input logic rw);
        bus.i_ex_alu_result = a;
        bus.i_ex_write_data = wd;
        bus.i_ex_rd         = rd;
        bus.i_ex_mem_read   = mr;
        bus.i_ex_mem_write  = mw;
        bus.i_ex_mem_to_reg = m2r;
        bus.i_ex_reg_write  = rw;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic m2r, input logic rw);
        set_in(a, wd, rd, mr, mw, m2r, rw);
        @(negedge clk);
    endtask

    task automatic nop();
        issue(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_m_alu"}, bus.o_ex_m_alu_result, 32'd0);
        check({tag, "_ex_m_rd"}, 32'(bus.o_ex_m_rd), 32'd0);
        check({tag, "_ex_m_rw"}, 32'(bus.o_ex_m_reg_write), 32'd0);
        check({tag, "_wb_data"}, bus.o_m_wb_data_write, 32'd0);
        check({tag, "_wb_rd"}, 32'(bus.o_m_wb_rd), 32'd0);
        check({tag, "_wb_rw"}, 32'(bus.o_m_wb_reg_write), 32'd0);
        check({tag, "_dbg"}, dbg_data, 32'd0);
        check({tag, "_misaligned"}, 32'(misaligned), 32'd0);
    endtask

    logic [31:0] fill_data [DEPTH];
    logic [31:0] ra;
    logic [4:0]  rrd;
    int          kind;

    initial begin
        set_in(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            fill_data[i] = $urandom;
            issue(32'(i * 4), fill_data[i], 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        nop();
        nop();

        // Store then load the same word
        issue(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        nop();
        check("sw_lw_wb_data", bus.o_m_wb_data_write, 32'hDEADBEEF);
        check("sw_lw_wb_rd", 32'(bus.o_m_wb_rd), 32'd5);
        check("sw_lw_wb_rw", 32'(bus.o_m_wb_reg_write), 32'd1);

        // ALU pass-through
        issue(32'h1234, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        check("alu_ex_m_result", bus.o_ex_m_alu_result, 32'h1234);
        check("alu_ex_m_rd", 32'(bus.o_ex_m_rd), 32'd3);
        nop();
        check("alu_wb_data", bus.o_m_wb_data_write, 32'h1234);

        // $zero masking
        issue(32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("zero_ex_m_rw", 32'(bus.o_ex_m_reg_write), 32'd0);
        nop();
        check("zero_wb_rw", 32'(bus.o_m_wb_reg_write), 32'd0);

        // Halt with a store held in EX/MEM
        issue(32'h777, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(32'h40, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        halt     = 1'b1;
        dbg_addr = 8'd16;
        set_in(32'h999, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_dbg_old", dbg_data, fill_data[16]);
            check("halt_ex_m_alu", bus.o_ex_m_alu_result, 32'h40);
            check("halt_wb_data", bus.o_m_wb_data_write, 32'h777);
            check("halt_wb_rd", 32'(bus.o_m_wb_rd), 32'd6);
        end
        halt = 1'b0;
        @(negedge clk);
        check("unhalt_dbg_same_cycle", dbg_data, fill_data[16]);
        check("unhalt_ex_m_alu", bus.o_ex_m_alu_result, 32'h999);
        check("unhalt_wb_data", bus.o_m_wb_data_write, 32'h40);
        nop();
        check("unhalt_dbg_new", dbg_data, 32'hCAFEF00D);

        // Randomized traffic over a small window of words, random upper bits
        for (int c = 0; c < 3000; c++) begin
            kind     = $urandom_range(0, 3);
            ra       = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            rrd      = 5'($urandom);
            halt     = ($urandom_range(0, 9) == 0);
            dbg_addr = 8'($urandom_range(0, 15));
            case (kind)
                0:       issue(ra, 32'h0, rrd, 1'b0, 1'b0, 1'b0, 1'b1);
                1:       issue(ra, $urandom, rrd, 1'b1, 1'b0, 1'b1, 1'b1);
                2:       issue(ra, $urandom, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
                default: issue(ra, $urandom, rrd, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
        end
        halt = 1'b0;
        nop();
        nop();

        // Misaligned store and load
        dbg_addr = 8'd8;
        issue(32'h20, 32'h13579BDF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(32'h22, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        nop();
        check("mis_flag_set", 32'(misaligned), 32'd1);
        nop();
        nop();
        check("mis_dbg_word8", dbg_data, 32'h13579BDF);
        issue(32'h20, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        nop();
        check("mis_aligned_lw", bus.o_m_wb_data_write, 32'h13579BDF);
        check("mis_aligned_lw_rd", 32'(bus.o_m_wb_rd), 32'd7);
        issue(32'h21, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        nop();
        check("mis_lw_zero", bus.o_m_wb_data_write, 32'h0);
        repeat (3) nop();
        check("mis_flag_sticky", 32'(misaligned), 32'd1);

        // Async reset between edges discards an uncommitted store
        issue(32'h44, 32'h0BADF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_in(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        dbg_addr = 8'd17;
        nop();
        nop();
        check("reset_store_lost", dbg_data, fill_data[17]);
        check("reset_mis_clear", 32'(misaligned), 32'd0);

        // Address wrap: 0x400 maps to word 0
        dbg_addr = 8'd0;
        issue(32'h400, 32'hA5A50001, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        nop();
        nop();
        check("wrap_dbg_word0", dbg_data, 32'hA5A50001);
        repeat (3) nop();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, consuming the EX outputs: ALU result, store data, destination register and MEM/WB control bits.
- Contains the EX/MEM latch, a word-addressed data memory and the MEM/WB latch.
- Returns the EX/MEM and MEM/WB forwarding values (ALU result / write-back data, rd, reg_write) to the EX forwarding muxes.
- Provides a read-only debug port into data memory for the debug unit.

Parameters:
- MEM_ADDR_BITS, 8, word-address width; memory depth is 2^MEM_ADDR_BITS 32-bit words.
- DATA_WIDTH, 32, datapath width.

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset (0 = reset)
- i_halt  in  1  freeze: latches hold, memory writes suppressed
- i_ex_alu_result  in  32  EX ALU result / effective address
- i_ex_write_data  in  32  store data (post-forwarding rt)
- i_ex_rd  in  5  EX destination register
- i_ex_mem_read  in  1  load
- i_ex_mem_write  in  1  store
- i_ex_mem_to_reg  in  1  write-back selects memory data
- i_ex_reg_write  in  1  write-back enable
- i_dbg_addr  in  MEM_ADDR_BITS  debug word address
- o_ex_m_alu_result  out  32  EX/MEM latched ALU result (forwarding to EX)
- o_ex_m_rd  out  5  EX/MEM latched rd
- o_ex_m_reg_write  out  1  EX/MEM latched reg_write
- o_m_wb_data_write  out  32  MEM/WB write-back value
- o_m_wb_rd  out  5  MEM/WB rd
- o_m_wb_reg_write  out  1  MEM/WB reg_write
- o_dbg_data  out  32  registered debug read data
- o_misaligned  out  1  sticky misaligned-access flag

Behaviour:
- Reset (i_reset=0, async): all EX/MEM and MEM/WB latch fields, o_dbg_data and o_misaligned go to 0. Memory contents are not cleared.
- EX/MEM latch captures all i_ex_* fields on every rising edge when i_halt=0.
  - reg_write is stored as i_ex_reg_write AND (i_ex_rd != 0), so $zero is never a forwarding or write-back target.
- Address: word index = ex_m_alu_result[MEM_ADDR_BITS+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- Misaligned access: ex_m_alu_result[1:0] != 0 with mem_read or mem_write latched.
  - A misaligned store is dropped.
  - A misaligned load returns 0.
  - o_misaligned is set on the following edge and holds until reset.
- Store: memory word is written at the rising edge ending the cycle in which EX/MEM holds mem_write=1, provided the access is aligned and i_halt=0.
- Load: combinational array read at the EX/MEM address, captured into MEM/WB at the same edge.
- MEM/WB latch captures rd, reg_write and the write-back value when i_halt=0.
  - Write-back value = mem_to_reg ? read_data : alu_result.
- Latency: EX outputs present in cycle N → o_ex_m_* valid in cycle N+1 → o_m_wb_* valid in cycle N+2.
- Store in cycle N+1 followed by load of the same word in cycle N+2: the load returns the new data (write-before-read across cycles, no stall needed).
- Store and load in the same EX/MEM entry: only one is legal from control. If both are set, the write occurs and the read returns the old word.
- i_halt=1:
  - Every latch and o_misaligned hold.
  - No memory write occurs.
  - On deassertion, the held instruction completes normally, including its pending store.
- Debug port: o_dbg_data <= mem[i_dbg_addr] on every edge, including during halt. The port is read-only and has 1-cycle latency.
  - A same-cycle store to that address: the debug port returns the old word, and the new word one cycle later.
- Reset asserted mid-operation: in-flight latch contents are discarded. Any store not yet committed at an edge is lost.

Test Plan:
- Store then load: sw with alu_result=0x10, data=0xDEADBEEF, then lw with alu_result=0x10, rd=5, mem_to_reg=1 → two cycles after the lw enters, o_m_wb_data_write=0xDEADBEEF, o_m_wb_rd=5, o_m_wb_reg_write=1.
- ALU pass-through: R-type with alu_result=0x1234, rd=3, reg_write=1, mem_to_reg=0.
  - Next cycle: o_ex_m_alu_result=0x1234, o_ex_m_rd=3.
  - Cycle after: o_m_wb_data_write=0x1234.
- $zero masking: reg_write=1 with rd=0 → o_ex_m_reg_write=0 and o_m_wb_reg_write=0.
- Misaligned store:
  - sw at 0x22 with data 0xFFFFFFFF → o_misaligned=1 and stays 1.
  - Debug read of word 8 still shows its prior value.
  - A subsequent aligned lw at 0x20 returns the prior value.
- Halt:
  - Assert i_halt with a sw to 0x40 in EX/MEM → memory word 16 is unchanged and all outputs hold for 5 cycles.
  - Deassert i_halt → the word is written on the next edge.
- Async reset and wrap:
  - Pull i_reset low between edges → all outputs are 0 immediately.
  - After release, sw to 0x400 (MEM_ADDR_BITS=8) → debug read of address 0 returns the stored data.
